shift_seq_controller: RTL

Sequencing controller for the team's loadable left-shift register: on a `start` request it issues one parallel-load pulse, then exactly `SIZE` shift pulses, then a one-cycle `done` pulse. While the shift pulses run, the register MSB streams serially to a downstream consumer. The block sits beside the shift register in the serialiser datapath, drives its `ldEN`/`shEN` inputs directly, and owns the start/busy/done handshake towards the upstream requester.

---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/shift_seq_counter.sv | 43 ++++
 rtl/shift_seq_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register sequencing controller.
// Optional build feature elsewhere: SHIFT_PAUSE_EN (adds a pause input).
package shift_seq_pkg;

   // Default width of the controlled shift register.
   localparam int unsigned SIZE_DEFAULT = 9;

   // Controller states. Encodings are fixed so debug taps read consistently.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/shift_seq_counter.sv
// Saturating up-counter for the shift sequencer: synchronous clear, count
// enable, and a terminal flag that fires when the enabled increment is the
// one that reaches SIZE.
module shift_seq_counter #(
   parameter int SIZE  = 9,
   parameter int CNT_W = $clog2(SIZE + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(SIZE - 1);
   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(SIZE);

   logic [CNT_W-1:0] count_d, count_q;

   // Next count: clear wins over enable; increments stop at SIZE so no wrap.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != MAX_C)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = en_i && (count_q == LAST_C);

endmodule

// File: rtl/shift_seq_controller.sv
// Sequencer for a loadable left-shift register: one load pulse, SIZE shift
// pulses, then a one-cycle done pulse. Outputs are decoded from the state
// register and the shift counter.
// Build option: define SHIFT_PAUSE_EN to add a pause input that stalls the
// shift phase (shEN/bitValid drop, counter holds) for each cycle it is high.
//
// Handshake: start is a level request sampled only in IDLE; busy is high for
// the LOAD and SHIFT phases; done pulses for exactly one cycle afterwards.
// Requests seen outside IDLE are dropped, never queued.
module shift_seq_controller
   import shift_seq_pkg::*;
#(
   parameter int SIZE  = SIZE_DEFAULT,
   parameter int CNT_W = $clog2(SIZE + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SHIFT_PAUSE_EN
   input  logic             pause,
`endif
   output logic             ldEN,
   output logic             shEN,
   output logic             bitValid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output state_e           state_o
);

   state_e           state_d, state_q;
   logic             hold_w;
   logic             shift_go;
   logic             cnt_clr;
   logic             cnt_tc;
   logic [CNT_W-1:0] cnt_w;

`ifdef SHIFT_PAUSE_EN
   assign hold_w = pause;
`else
   assign hold_w = 1'b0;
`endif

   // A shift is issued in every SHIFT cycle that is not stalled.
   assign shift_go = (state_q == SHIFT) && !hold_w;

   shift_seq_counter #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W)
   ) u_counter (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (cnt_clr),
      .en_i    (shift_go),
      .count_o (cnt_w),
      .tc_o    (cnt_tc)
   );

   // State register; reset returns to IDLE from any phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode. The counter is cleared outside SHIFT so it
   // reads 0 in IDLE/LOAD, and it keeps SIZE through DONE before clearing.
   always_comb begin
      state_d  = state_q;
      ldEN     = 1'b0;
      shEN     = 1'b0;
      bitValid = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      cnt_clr  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            if (start) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            ldEN    = 1'b1;
            busy    = 1'b1;
            cnt_clr = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            busy     = 1'b1;
            shEN     = shift_go;
            bitValid = shift_go;
            if (cnt_tc) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            cnt_clr = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign count   = cnt_w;
   assign state_o = state_q;

endmodule
